io_stim_sequencer: RTL and testbench
====================================

# io_stim_sequencer

Synthesizable, programmable stimulus sequencer that replays a scripted list of switch settings and Run/Continue button presses into the SLC-3 top level. It replaces hand-timed board interaction and fixed-delay bench stimulus. Each step can wait a fixed number of cycles or wait for the CPU's pause indication, with a timeout. It sits between the board I/O (or bench) and the CPU's SW/Run/Continue inputs.

## Interface
- SW_W, 10: width of switch output
- STEPS, 16: program store depth (≥2, power of two)
- DELAY_W, 16: width of per-step delay/timeout field
- PULSE_CYC, 5: cycles a button output is held low per press (≥1)
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- Prog_we  in  1  write program entry; honoured only when Busy=0
- Prog_addr  in  $clog2(STEPS)  program entry index
- Prog_data  in  4+DELAY_W+SW_W  step word {op[1:0], mode[1:0], delay, sw}
- Start  in  1  one-cycle start pulse; ignored while Busy=1
- Paused  in  1  CPU pause indication (high while awaiting Continue)
- SW  out  SW_W  switch value driven to CPU
- Run  out  1  active-low Run button
- Continue  out  1  active-low Continue button
- Busy  out  1  sequence executing
- Done  out  1  sequence finished; sticky until next Start
- Timeout  out  1  wait-for-pause expired; sticky until next Start
- Step_idx  out  $clog2(STEPS)  index of current/last executed step

## Operation
- Ops: 0 END, 1 SET_SW (load sw field into SW), 2 PULSE_RUN, 3 PULSE_CONT. sw field ignored for ops 0, 2, 3.
- Modes: 0 fixed delay, 1 wait-for-pause, 2/3 treated as 0.
- States: IDLE, FETCH, PULSE, WAIT, DONE.
- IDLE/DONE + Start → FETCH with Step_idx=0; clears Done and Timeout.
- FETCH: latch entry[Step_idx]. Next state:
  - END → DONE
  - SET_SW: SW updates; → WAIT if delay≠0 or mode=1, else next step
  - PULSE_*: → PULSE
- PULSE: selected button low for PULSE_CYC cycles; then WAIT or next step, by the same rule.
- WAIT mode 0: delay cycles.
- WAIT mode 1: leave when Paused=1 is sampled high. If delay≠0 and delay cycles elapse without Paused, set Timeout → DONE (abort). delay=0 in mode 1 means no timeout.
- Next step: Step_idx+1 → FETCH. After index STEPS-1 with no END → DONE (no wrap).
- DONE: Done=1, Busy=0; SW holds last value; buttons high.
- Prog_we while Busy=1 is dropped. Program store is not reset; contents persist across Reset_n.

## Timing
- Reset values: SW=0, Run=1, Continue=1, Busy=0, Done=0, Timeout=0, Step_idx=0, state IDLE.
- Reset asserted mid-sequence: all outputs return to reset values immediately, so any button in progress releases asynchronously.
- All outputs are registered.
- Start sampled at edge k: Busy=1 and FETCH from k+1.
- SET_SW: SW changes on the edge leaving FETCH.
- Button goes low on the edge leaving FETCH and returns high exactly PULSE_CYC cycles later.
- Step period, mode 0: 1 + D for SET_SW; 1 + PULSE_CYC + D for pulses.
- Mode 1: Paused already high in the first WAIT cycle gives exactly 1 WAIT cycle.
- Paused and timeout expiring in the same cycle: Paused wins; no Timeout.
- Done asserts the cycle after FETCH of END, or the cycle after timeout/last-index completion.

## Structure
- Package io_stim_pkg holds:
  - op_e and mode_e enums
  - packed step_t struct {op, mode, delay, sw}, parameterised through localparams mirroring the defaults
  - STEP_W constant
- Sub-module stim_step_timer: loadable DELAY_W-bit down-counter with zero flag. It is shared by PULSE (loaded with PULSE_CYC) and WAIT (loaded with delay).

## Test plan
- Reset mid-PULSE_RUN → Run=1 immediately; SW=0, Busy=0, Done=0.
- Program {SET_SW 0x00B d0, PULSE_RUN d3, END}, Start → SW=0x00B one cycle after FETCH; Run low exactly 5 cycles; Done asserted 1+1+5+3+1 cycles after the first FETCH.
- {PULSE_CONT mode1 d20}, Paused driven high 7 cycles into WAIT → next FETCH follows; Timeout=0.
- Same program, Paused held low → Timeout=1 and Done=1 after 20 WAIT cycles.
- Same program with Paused rising exactly on the 20th WAIT cycle → Timeout=0.
- 16 SET_SW steps 0x001..0x010, no END → SW ends at 0x010; Done=1; Step_idx=15; no wrap.
- Prog_we and Start pulsed while Busy → program and sequence unaffected.

Source files
------------

// File: rtl/io_stim_pkg.sv
// Shared types and defaults for the stimulus sequencer: step word layout,
// op/mode encodings, FSM states and a small helper for the post-action rule.
package io_stim_pkg;

  localparam int SW_W_DEF      = 10;
  localparam int STEPS_DEF     = 16;
  localparam int DELAY_W_DEF   = 16;
  localparam int PULSE_CYC_DEF = 5;

  localparam int STEP_W = 4 + DELAY_W_DEF + SW_W_DEF;

  typedef enum logic [1:0] {
    OP_END        = 2'd0,
    OP_SET_SW     = 2'd1,
    OP_PULSE_RUN  = 2'd2,
    OP_PULSE_CONT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_PAUSE = 2'd1,
    MODE_RSVD2 = 2'd2,
    MODE_RSVD3 = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    op_e                    op;
    mode_e                  mode;
    logic [DELAY_W_DEF-1:0] delay;
    logic [SW_W_DEF-1:0]    sw;
  } step_t;

  // A step needs a WAIT phase when it has a delay or waits for the CPU pause.
  function automatic logic needs_wait(input mode_e mode, input logic delay_nz);
    return delay_nz || (mode == MODE_PAUSE);
  endfunction

endpackage

// File: rtl/stim_step_timer.sv
// Loadable down-counter shared by the PULSE and WAIT phases. It is loaded with
// the phase length minus one, so zero_o marks the final cycle of the phase.
module stim_step_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/io_stim_sequencer.sv
// Programmable stimulus sequencer: replays a stored list of switch settings
// and Run/Continue presses into the CPU, with fixed delays or pause waits.
module io_stim_sequencer
  import io_stim_pkg::*;
#(
  parameter int SW_W      = SW_W_DEF,
  parameter int STEPS     = STEPS_DEF,
  parameter int DELAY_W   = DELAY_W_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Prog_we,
  input  logic [$clog2(STEPS)-1:0] Prog_addr,
  input  logic [4+DELAY_W+SW_W-1:0] Prog_data,
  input  logic                     Start,
  input  logic                     Paused,
  output logic [SW_W-1:0]          SW,
  output logic                     Run,
  output logic                     Continue,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Timeout,
  output logic [$clog2(STEPS)-1:0] Step_idx
);

  localparam int IDX_W = $clog2(STEPS);
  localparam int WORD_W = 4 + DELAY_W + SW_W;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(STEPS - 1);
  localparam logic [DELAY_W-1:0] PULSE_LOAD = DELAY_W'(PULSE_CYC - 1);

  logic [WORD_W-1:0] mem_q [STEPS];

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SW_W-1:0]    sw_q, sw_d;
  logic               run_q, run_d;
  logic               cont_q, cont_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  op_e                op_q, op_d;
  mode_e              mode_q, mode_d;
  logic [DELAY_W-1:0] delay_q, delay_d;

  logic               tmr_load;
  logic [DELAY_W-1:0] tmr_val;
  logic               tmr_zero;
  logic               advance;

  logic [WORD_W-1:0]  entry;
  op_e                ent_op;
  mode_e              ent_mode;
  logic [DELAY_W-1:0] ent_delay;
  logic [SW_W-1:0]    ent_sw;

  assign entry     = mem_q[idx_q];
  assign ent_op    = op_e'(entry[WORD_W-1 -: 2]);
  assign ent_mode  = mode_e'(entry[WORD_W-3 -: 2]);
  assign ent_delay = entry[SW_W +: DELAY_W];
  assign ent_sw    = entry[SW_W-1:0];

  stim_step_timer #(.W(DELAY_W)) u_timer (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Program store: writable only while idle, deliberately not reset.
  always_ff @(posedge Clk) begin
    if (Prog_we && !busy_q) begin
      mem_q[Prog_addr] <= Prog_data;
    end
  end

  // Next-state and registered-output decode for the step FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sw_d      = sw_q;
    run_d     = 1'b1;
    cont_d    = 1'b1;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    op_d      = op_q;
    mode_d    = mode_q;
    delay_d   = delay_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    advance   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d   = ST_FETCH;
          idx_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_FETCH: begin
        op_d    = ent_op;
        mode_d  = ent_mode;
        delay_d = ent_delay;
        unique case (ent_op)
          OP_END: begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          OP_SET_SW: begin
            sw_d = ent_sw;
            if (needs_wait(ent_mode, ent_delay != '0)) begin
              state_d  = ST_WAIT;
              tmr_load = 1'b1;
              tmr_val  = ent_delay - DELAY_W'(1);
            end else begin
              advance = 1'b1;
            end
          end
          default: begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LOAD;
            run_d    = (ent_op != OP_PULSE_RUN);
            cont_d   = (ent_op != OP_PULSE_CONT);
          end
        endcase
      end
      ST_PULSE: begin
        if (!tmr_zero) begin
          run_d  = (op_q != OP_PULSE_RUN);
          cont_d = (op_q != OP_PULSE_CONT);
        end else if (needs_wait(mode_q, delay_q != '0)) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = delay_q - DELAY_W'(1);
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mode_q == MODE_PAUSE) begin
          if (Paused) begin
            advance = 1'b1;
          end else if ((delay_q != '0) && tmr_zero) begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end else if (tmr_zero) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_FETCH;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and latched step context.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_q     <= '0;
      sw_q      <= '0;
      run_q     <= 1'b1;
      cont_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      op_q      <= OP_END;
      mode_q    <= MODE_FIXED;
      delay_q   <= '0;
    end else begin
      idx_q     <= idx_d;
      sw_q      <= sw_d;
      run_q     <= run_d;
      cont_q    <= cont_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      op_q      <= op_d;
      mode_q    <= mode_d;
      delay_q   <= delay_d;
    end
  end

  assign SW       = sw_q;
  assign Run      = run_q;
  assign Continue = cont_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Timeout  = timeout_q;
  assign Step_idx = idx_q;

endmodule

// File: tb/tb_io_stim_sequencer.sv
// Self-checking bench for io_stim_sequencer: a step-level timeline model
// predicts every output for every cycle of a sequence run.
module tb_io_stim_sequencer;
  import io_stim_pkg::*;

  localparam int SW_W      = 10;
  localparam int STEPS     = 16;
  localparam int DELAY_W   = 16;
  localparam int PULSE_CYC = 5;
  localparam int MAXC      = 2048;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              Prog_we;
  logic [3:0]        Prog_addr;
  logic [STEP_W-1:0] Prog_data;
  logic              Start;
  logic              Paused;
  logic [SW_W-1:0]   SW;
  logic              Run;
  logic              Continue;
  logic              Busy;
  logic              Done;
  logic              Timeout;
  logic [3:0]        Step_idx;

  io_stim_sequencer #(
    .SW_W(SW_W), .STEPS(STEPS), .DELAY_W(DELAY_W), .PULSE_CYC(PULSE_CYC)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Prog_we(Prog_we), .Prog_addr(Prog_addr),
    .Prog_data(Prog_data), .Start(Start), .Paused(Paused), .SW(SW), .Run(Run),
    .Continue(Continue), .Busy(Busy), .Done(Done), .Timeout(Timeout),
    .Step_idx(Step_idx)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int progOp[STEPS];
  int progMode[STEPS];
  int progDelay[STEPS];
  int progSw[STEPS];
  bit pausedSched[MAXC];

  int expSw[MAXC];
  int expRun[MAXC];
  int expCont[MAXC];
  int expBusy[MAXC];
  int expDone[MAXC];
  int expTo[MAXC];
  int expIdx[MAXC];
  int modelSw;

  task automatic checkOutput(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  function automatic void setCycle(int n, int sw, int run, int cont, int busy, int done, int to, int idx);
    expSw[n] = sw; expRun[n] = run; expCont[n] = cont; expBusy[n] = busy;
    expDone[n] = done; expTo[n] = to; expIdx[n] = idx;
  endfunction

  // Walk the program step by step, producing the per-cycle output timeline
  // (cycle 0 = first cycle with Busy high). Returns the first Done cycle.
  function automatic int buildModel();
    int c, t, wlen;
    bit to;
    int curSw;
    curSw = modelSw;
    c = 0;
    for (int s = 0; s < STEPS; s++) begin
      setCycle(c, curSw, 1, 1, 1, 0, 0, s);
      if (progOp[s] == 0) begin
        setCycle(c + 1, curSw, 1, 1, 0, 1, 0, s);
        modelSw = curSw;
        return c + 1;
      end
      if (progOp[s] == 1) curSw = progSw[s];
      t = c + 1;
      if (progOp[s] >= 2) begin
        for (int j = 0; j < PULSE_CYC; j++)
          setCycle(t + j, curSw, (progOp[s] == 2) ? 0 : 1, (progOp[s] == 3) ? 0 : 1, 1, 0, 0, s);
        t += PULSE_CYC;
      end
      if (progMode[s] == 1) begin
        wlen = 0;
        to = 0;
        for (int j = 0; t + j < MAXC - 2; j++) begin
          wlen = j + 1;
          if (pausedSched[t + j]) break;
          if (progDelay[s] != 0 && j == progDelay[s] - 1) begin
            to = 1;
            break;
          end
        end
        for (int j = 0; j < wlen; j++) setCycle(t + j, curSw, 1, 1, 1, 0, 0, s);
        t += wlen;
        if (to) begin
          setCycle(t, curSw, 1, 1, 0, 1, 1, s);
          modelSw = curSw;
          return t;
        end
      end else begin
        for (int j = 0; j < progDelay[s]; j++) setCycle(t + j, curSw, 1, 1, 1, 0, 0, s);
        t += progDelay[s];
      end
      c = t;
    end
    setCycle(c, curSw, 1, 1, 0, 1, 0, STEPS - 1);
    modelSw = curSw;
    return c;
  endfunction

  function automatic logic [STEP_W-1:0] packWord(int op, int mode, int delay, int sw);
    step_t st;
    st.op    = op_e'(op[1:0]);
    st.mode  = mode_e'(mode[1:0]);
    st.delay = DELAY_W'(delay);
    st.sw    = SW_W'(sw);
    return st;
  endfunction

  function automatic void clearProg();
    for (int i = 0; i < STEPS; i++) begin
      progOp[i] = 0; progMode[i] = 0; progDelay[i] = 0; progSw[i] = 0;
    end
    for (int i = 0; i < MAXC; i++) pausedSched[i] = 0;
  endfunction

  function automatic void setStep(int i, int op, int mode, int delay, int sw);
    progOp[i] = op; progMode[i] = mode; progDelay[i] = delay; progSw[i] = sw;
  endfunction

  // Load the whole program store, then pulse Start; returns in cycle 0.
  task automatic applyStimulus();
    for (int i = 0; i < STEPS; i++) begin
      Prog_we   = 1'b1;
      Prog_addr = 4'(i);
      Prog_data = packWord(progOp[i], progMode[i], progDelay[i], progSw[i]);
      @(posedge Clk); #1;
    end
    Prog_we = 1'b0;
    Start   = 1'b1;
    @(posedge Clk); #1;
    Start   = 1'b0;
  endtask

  task automatic runSequence(input bit disturb);
    int last;
    last = buildModel();
    applyStimulus();
    for (int n = 0; n <= last; n++) begin
      Paused = pausedSched[n];
      if (disturb && n == 2 && last > 3) begin
        Prog_we   = 1'b1;
        Prog_addr = 4'($urandom_range(0, STEPS - 1));
        Prog_data = STEP_W'($urandom);
        Start     = 1'b1;
      end
      @(negedge Clk);
      checkOutput("sw",      n, 32'(SW),       32'(expSw[n]));
      checkOutput("run",     n, 32'(Run),      32'(expRun[n]));
      checkOutput("cont",    n, 32'(Continue), 32'(expCont[n]));
      checkOutput("busy",    n, 32'(Busy),     32'(expBusy[n]));
      checkOutput("done",    n, 32'(Done),     32'(expDone[n]));
      checkOutput("timeout", n, 32'(Timeout),  32'(expTo[n]));
      checkOutput("idx",     n, 32'(Step_idx), 32'(expIdx[n]));
      @(posedge Clk); #1;
      Prog_we = 1'b0;
      Start   = 1'b0;
    end
    Paused = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  function automatic void randomProgram();
    int r;
    clearProg();
    for (int i = 0; i < STEPS; i++) begin
      r = $urandom_range(0, 19);
      progOp[i]    = (r == 0) ? 0 : (r <= 9) ? 1 : (r <= 15) ? 2 : 3;
      progMode[i]  = $urandom_range(0, 3);
      progDelay[i] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
      progSw[i]    = $urandom_range(0, 1023);
    end
    for (int n = 0; n < MAXC; n++)
      pausedSched[n] = ($urandom_range(0, 5) == 0) || (n % 16 == 15);
  endfunction

  initial begin
    Reset_n = 1'b0; Prog_we = 1'b0; Prog_addr = '0; Prog_data = '0;
    Start = 1'b0; Paused = 1'b0;
    modelSw = 0;

    #12;
    checkOutput("rst_sw",      0, 32'(SW),       32'd0);
    checkOutput("rst_run",     0, 32'(Run),      32'd1);
    checkOutput("rst_cont",    0, 32'(Continue), 32'd1);
    checkOutput("rst_busy",    0, 32'(Busy),     32'd0);
    checkOutput("rst_done",    0, 32'(Done),     32'd0);
    checkOutput("rst_timeout", 0, 32'(Timeout),  32'd0);
    checkOutput("rst_idx",     0, 32'(Step_idx), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Reset asserted while Run is held low must release it at once.
    clearProg();
    setStep(0, 1, 0, 0, 'h155);
    setStep(1, 2, 0, 0, 0);
    applyStimulus();
    @(posedge Clk); #1;
    @(posedge Clk); #3;
    checkOutput("pre_rst_run", 2, 32'(Run), 32'd0);
    Reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_run",  2, 32'(Run),      32'd1);
    checkOutput("mid_rst_sw",   2, 32'(SW),       32'd0);
    checkOutput("mid_rst_busy", 2, 32'(Busy),     32'd0);
    checkOutput("mid_rst_done", 2, 32'(Done),     32'd0);
    checkOutput("mid_rst_idx",  2, 32'(Step_idx), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    modelSw = 0;
    @(posedge Clk); #1;

    // SET_SW, PULSE_RUN with trailing delay, END.
    clearProg();
    setStep(0, 1, 0, 0, 'h00B);
    setStep(1, 2, 0, 3, 0);
    runSequence(1'b0);

    // PULSE_CONT waiting for pause, Paused arrives 7 cycles into WAIT.
    clearProg();
    setStep(0, 3, 1, 20, 0);
    for (int n = 13; n < 40; n++) pausedSched[n] = 1'b1;
    runSequence(1'b0);

    // Same program, Paused never arrives: timeout.
    clearProg();
    setStep(0, 3, 1, 20, 0);
    runSequence(1'b0);

    // Paused rises exactly on the last WAIT cycle: pause wins.
    clearProg();
    setStep(0, 3, 1, 20, 0);
    pausedSched[25] = 1'b1;
    runSequence(1'b0);

    // Sixteen SET_SW steps with no END: runs off the end, no wrap.
    clearProg();
    for (int i = 0; i < STEPS; i++) setStep(i, 1, 0, 0, i + 1);
    runSequence(1'b0);

    // Prog_we and Start while busy are dropped; rerun proves store intact.
    clearProg();
    setStep(0, 1, 0, 2, 'h2A5);
    setStep(1, 2, 0, 1, 0);
    setStep(2, 3, 0, 0, 0);
    setStep(3, 1, 2, 4, 'h0F0);
    runSequence(1'b1);
    runSequence(1'b0);

    // Randomised programs and pause patterns.
    for (int k = 0; k < 8; k++) begin
      randomProgram();
      runSequence(k == 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
